// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
// Shared definitions for the pipelined immediate-extension unit:
//   - imm_mode_e      : 2-bit extension mode (ZERO, SIGN, HIGH, BRANCH)
//   - slice_payload_t : contents of one pipeline slice (data, tag, err)
// The payload struct is sized for the widest legal configuration.
// The top level zero-pads narrower operands into it. Synthesis trims
// the constant upper bits.
package imm_ext_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_TAG_W  = 16;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_HIGH   = 2'd2,
    EXT_BRANCH = 2'd3
  } imm_mode_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_TAG_W-1:0]  tag;
    logic                  err;
  } slice_payload_t;

endpackage

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
// One valid/ready register slice.
//   clk, rst_n              : clock, asynchronous active-low reset
//   up_valid/up_ready/up_data       : upstream handshake and payload
//   down_valid/down_ready/down_data : downstream handshake and payload
// The slice reloads whenever it is empty or its content leaves this cycle.
// As a result, an empty slice never stalls its upstream and bubbles collapse.
module imm_ext_stage
  import imm_ext_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_valid,
  output logic           up_ready,
  input  slice_payload_t up_data,
  output logic           down_valid,
  input  logic           down_ready,
  output slice_payload_t down_data
);

  logic           valid_r;
  slice_payload_t data_r;
  logic           load_s;

  // Empty, or occupied and advancing: either way the slot is free at the edge.
  assign load_s     = !valid_r || down_ready;
  assign up_ready   = load_s;
  assign down_valid = valid_r;
  assign down_data  = data_r;

  // Valid bit: follows upstream valid whenever the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= up_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: captured only on a real transfer so stalled outputs hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (load_s && up_valid) begin
      data_r <= up_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
// Pipelined immediate extender with valid/ready flow control.
// It has a fixed STAGES-cycle latency when unstalled.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_valid/in_ready            : operand handshake
//   in_imm[IN_W], in_mode[2]     : raw immediate and extension mode
//   in_tag[TAG_W]                : sideband tag, carried unchanged
//   out_valid/out_ready          : result handshake
//   out_data[OUT_W], out_tag, out_err : extended value, tag, illegal-mode flag
// Build option: IMM_EXT_BRANCH_EN enables the BRANCH mode (sign-extend << 2).
// Without it, mode 3 yields out_data=0 and out_err=1.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int PAD_W = OUT_W - IN_W;

  if (IN_W < 4 || IN_W > 32 || OUT_W < IN_W + 2 || OUT_W > MAX_DATA_W ||
      STAGES < 1 || STAGES > 4 || TAG_W < 1 || TAG_W > MAX_TAG_W) begin : g_bad_params
    $error("imm_ext_pipe: illegal parameters IN_W=%0d OUT_W=%0d STAGES=%0d TAG_W=%0d",
           IN_W, OUT_W, STAGES, TAG_W);
  end

  logic [OUT_W-1:0] sext_s;
  logic [OUT_W-1:0] ext_data_s;
  logic             ext_err_s;
  slice_payload_t   in_payload_s;

  assign sext_s = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  // Extension multiplexer feeding slice 0.
  always_comb begin
    ext_data_s = {OUT_W{1'b0}};
    ext_err_s  = 1'b0;
    case (imm_mode_e'(in_mode))
      EXT_ZERO: ext_data_s = {{PAD_W{1'b0}}, in_imm};
      EXT_SIGN: ext_data_s = sext_s;
      EXT_HIGH: ext_data_s = {in_imm, {PAD_W{1'b0}}};
      EXT_BRANCH: begin
`ifdef IMM_EXT_BRANCH_EN
        // PAD_W >= 2, so the two bits shifted out are sign copies.
        ext_data_s = {sext_s[OUT_W-3:0], 2'b00};
        ext_err_s  = 1'b0;
`else
        ext_data_s = {OUT_W{1'b0}};
        ext_err_s  = 1'b1;
`endif
      end
      default: begin
        ext_data_s = {OUT_W{1'b0}};
        ext_err_s  = 1'b1;
      end
    endcase
  end

  assign in_payload_s.data = MAX_DATA_W'(ext_data_s);
  assign in_payload_s.tag  = MAX_TAG_W'(in_tag);
  assign in_payload_s.err  = ext_err_s;

  // Index k is the boundary feeding slice k. Index STAGES is the unit output.
  logic           valid_s   [STAGES+1];
  logic           ready_s   [STAGES+1];
  slice_payload_t payload_s [STAGES+1];

  assign valid_s[0]      = in_valid;
  assign payload_s[0]    = in_payload_s;
  assign in_ready        = ready_s[0];
  assign ready_s[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    imm_ext_stage u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (valid_s[k]),
      .up_ready   (ready_s[k]),
      .up_data    (payload_s[k]),
      .down_valid (valid_s[k+1]),
      .down_ready (ready_s[k+1]),
      .down_data  (payload_s[k+1])
    );
  end

  assign out_valid = valid_s[STAGES];
  assign out_data  = payload_s[STAGES].data[OUT_W-1:0];
  assign out_tag   = payload_s[STAGES].tag[TAG_W-1:0];
  assign out_err   = payload_s[STAGES].err;

  // Padding bits above OUT_W/TAG_W are constant zero and intentionally unread.
  logic unused_pad_s;
  assign unused_pad_s = |{payload_s[STAGES].data >> OUT_W, payload_s[STAGES].tag >> TAG_W};

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe. It has one directed instance with
// STAGES=2 and two random-sweep instances with STAGES=1 and STAGES=4.
module tb_imm_ext_pipe;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

`ifdef IMM_EXT_BRANCH_EN
  localparam logic [31:0] BR_FFFF_DATA = 32'hFFFF_FFFC;
  localparam logic [31:0] BR_7FFF_DATA = 32'h0001_FFFC;
  localparam logic        BR_ERR       = 1'b0;
`else
  localparam logic [31:0] BR_FFFF_DATA = 32'h0000_0000;
  localparam logic [31:0] BR_7FFF_DATA = 32'h0000_0000;
  localparam logic        BR_ERR       = 1'b1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t ref_ext(input logic [15:0] imm, input logic [1:0] mode,
                                   input logic [4:0] tag);
    exp_t e;
    e.tag = tag;
    e.err = 1'b0;
    case (mode)
      2'd0:    e.data = {16'h0000, imm};
      2'd1:    e.data = {{16{imm[15]}}, imm};
      2'd2:    e.data = {imm, 16'h0000};
      default: begin
`ifdef IMM_EXT_BRANCH_EN
        e.data = {{14{imm[15]}}, imm, 2'b00};
`else
        e.data = 32'h0000_0000;
        e.err  = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  // ---------------- directed instance ----------------
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2), .TAG_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  exp_t exp_q[$];
  int   pop_cyc_q[$];
  int   accept_cyc;
  int   pops = 0;

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                      input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    forever begin
      #1;
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    accept_cyc = cyc;
    e.data = exp_data; e.tag = tag; e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: pops on each output transfer and checks hold stability while stalled.
  initial begin
    exp_t        e;
    logic [37:0] held;
    logic        hold_have = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid) begin
        if (!out_ready) begin
          if (hold_have) check("hold_stable", 64'({out_data, out_tag, out_err}), 64'(held));
          held = {out_data, out_tag, out_err};
          hold_have = 1'b1;
        end else begin
          hold_have = 1'b0;
          pops++;
          pop_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(out_data), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_tag",  64'(out_tag),  64'(e.tag));
            check("out_err",  64'(out_err),  64'(e.err));
          end
        end
      end else begin
        hold_have = 1'b0;
      end
    end
  end

  // ---------------- random sweep instances ----------------
  logic sw_rst_n;
  logic sw_done [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int ST = (g == 0) ? 1 : 4;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
    logic [15:0] s_imm;
    logic [1:0]  s_mode;
    logic [4:0]  s_tag, s_out_tag;
    logic [31:0] s_out_data;
    logic        drain = 1'b0;
    int          s_pops = 0;
    exp_t        q[$];

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(ST), .TAG_W(5)) u_sw (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_imm(s_imm), .in_mode(s_mode), .in_tag(s_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_tag(s_out_tag), .out_err(s_out_err)
    );

    initial begin
      s_out_ready = 1'b0;
      forever begin
        @(negedge clk);
        s_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk); #2;
        if (sw_rst_n && s_out_valid && s_out_ready) begin
          s_pops++;
          if (q.size() == 0) begin
            check("sweep_unexpected", 64'(s_out_data), 64'd0);
          end else begin
            e = q.pop_front();
            check("sweep_data", 64'({s_out_data, s_out_tag, s_out_err}),
                  64'({e.data, e.tag, e.err}));
          end
        end
      end
    end

    initial begin
      int n;
      sw_done[g] = 1'b0;
      s_in_valid = 1'b0; s_imm = 16'h0000; s_mode = 2'd0; s_tag = 5'd0;
      wait (sw_rst_n);
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          s_in_valid = 1'b0;
          @(negedge clk);
        end
        s_in_valid = 1'b1;
        s_imm  = 16'($urandom);
        s_mode = 2'($urandom_range(0, 3));
        s_tag  = 5'($urandom_range(0, 31));
        n = 0;
        forever begin
          #1;
          if (s_in_ready || n > 200) break;
          n++;
          @(negedge clk);
        end
        if (n > 200) check("sweep_send_timeout", 64'd0, 64'd1);
        else q.push_back(ref_ext(s_imm, s_mode, s_tag));
        @(negedge clk);
      end
      s_in_valid = 1'b0;
      drain = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      #3;
      check("sweep_drained", 64'(q.size()), 64'd0);
      check("sweep_count", 64'(s_pops), 64'd1000);
      sw_done[g] = 1'b1;
    end
  end

  initial begin
    sw_rst_n = 1'b0;
    #22 sw_rst_n = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a0, c0, p0, n;
    rst_n = 1'b0; in_valid = 1'b0; in_imm = 16'h0000; in_mode = 2'd0; in_tag = 5'd0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ZERO/SIGN/HIGH back-to-back, latency and throughput
    out_ready = 1'b1;
    pop_cyc_q.delete();
    send(16'h8001, 2'd0, 5'd1, 32'h0000_8001, 1'b0);
    a0 = accept_cyc;
    send(16'h8001, 2'd1, 5'd2, 32'hFFFF_8001, 1'b0);
    send(16'h8001, 2'd2, 5'd3, 32'h8001_0000, 1'b0);
    repeat (5) @(negedge clk);
    check("b2b_count", 64'(pop_cyc_q.size()), 64'd3);
    if (pop_cyc_q.size() == 3) begin
      check("latency",  64'(pop_cyc_q[0] - a0),           64'd2);
      check("tput_1_2", 64'(pop_cyc_q[1] - pop_cyc_q[0]), 64'd1);
      check("tput_2_3", 64'(pop_cyc_q[2] - pop_cyc_q[1]), 64'd1);
    end

    // BRANCH and extra patterns
    send(16'hFFFF, 2'd3, 5'd7,  BR_FFFF_DATA, BR_ERR);
    send(16'h7FFF, 2'd3, 5'd8,  BR_7FFF_DATA, BR_ERR);
    send(16'hFFFF, 2'd0, 5'd9,  32'h0000_FFFF, 1'b0);
    send(16'h1234, 2'd2, 5'd10, 32'h1234_0000, 1'b0);
    send(16'h7FFF, 2'd1, 5'd11, 32'h0000_7FFF, 1'b0);
    repeat (5) @(negedge clk);

    // Backpressure: stream 1..5 with out_ready low, then release
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(16'(i), 2'd0, 5'(i), 32'(i), 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        check("bp_in_ready_low", 64'(in_ready),      64'd0);
        check("bp_accepted",     64'(exp_q.size()),  64'd2);
        check("bp_out_valid",    64'(out_valid),     64'd1);
        @(negedge clk);
        pop_cyc_q.delete();
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check("bp_count", 64'(pop_cyc_q.size()), 64'd5);
    if (pop_cyc_q.size() == 5)
      for (int i = 1; i < 5; i++)
        check("bp_one_per_cycle", 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'd1);

    // Full pipe, then drain and accept in the same cycle
    out_ready = 1'b0;
    send(16'h0010, 2'd0, 5'd12, 32'h0000_0010, 1'b0);
    send(16'h0011, 2'd0, 5'd13, 32'h0000_0011, 1'b0);
    #1;
    check("full_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    c0 = cyc;
    send(16'h0012, 2'd0, 5'd14, 32'h0000_0012, 1'b0);
    check("full_drain_accept_same_cycle", 64'(accept_cyc), 64'(c0));
    repeat (5) @(negedge clk);
    check("full_drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two operands in flight
    out_ready = 1'b0;
    send(16'h00AA, 2'd1, 5'd20, 32'h0000_00AA, 1'b0);
    send(16'h00BB, 2'd1, 5'd21, 32'h0000_00BB, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = pops;
    repeat (6) @(negedge clk);
    check("no_stale_after_reset", 64'(pops - p0), 64'd0);
    send(16'h0042, 2'd1, 5'd22, 32'h0000_0042, 1'b0);
    repeat (5) @(negedge clk);
    check("final_empty", 64'(exp_q.size()), 64'd0);

    n = 0;
    while (!(sw_done[0] && sw_done[1]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("sweeps_finished", 64'(sw_done[0] && sw_done[1]), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
